// File: rtl/analog_pin_sampler.sv
// Synchronises the pin-out block's analog pins and counts high samples per pin
// over a programmable window, returning the counts through a valid/ready handshake.
module analog_pin_sampler #(
  parameter int NUM_PINS      = 6,
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [CNT_W-1:0]          window,
  input  logic [NUM_PINS-1:0]       analog_in,
  output logic                      busy,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic [NUM_PINS*CNT_W-1:0] result_counts
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t              state;
  state_t              state_next;
  logic [NUM_PINS-1:0] sync1;
  logic [NUM_PINS-1:0] sync2;
  logic [CNT_W-1:0]    window_q;
  logic [CNT_W-1:0]    sample_cnt;
  logic [7:0]          settle_cnt;
  logic [CNT_W-1:0]    counts [NUM_PINS];
  logic                accept;
  logic                settle_last;
  logic                sample_last;

  assign accept      = (state == IDLE) && start;
  assign settle_last = (settle_cnt == 8'(SETTLE_CYCLES - 1));
  assign sample_last = (sample_cnt == window_q - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start) state_next = SETTLE;
      SETTLE: if (settle_last) state_next = (window_q == '0) ? DONE : SAMPLE;
      SAMPLE: if (sample_last) state_next = DONE;
      DONE:   if (result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    result_valid = (state == DONE);
  end

  // Two-flop synchroniser; the settle interval absorbs its latency before sampling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= analog_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_q   <= '0;
      settle_cnt <= '0;
      sample_cnt <= '0;
    end else if (accept) begin
      window_q   <= window;
      settle_cnt <= '0;
      sample_cnt <= '0;
    end else begin
      if (state == SETTLE) settle_cnt <= settle_cnt + 8'd1;
      if (state == SAMPLE) sample_cnt <= sample_cnt + CNT_W'(1);
    end
  end

  // A count can never exceed the window, so plain addition cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PINS; i++) counts[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_PINS; i++) counts[i] <= '0;
    end else if (state == SAMPLE) begin
      for (int i = 0; i < NUM_PINS; i++) counts[i] <= counts[i] + CNT_W'(sync2[i]);
    end
  end

  always_comb begin
    result_counts = '0;
    for (int i = 0; i < NUM_PINS; i++) result_counts[i*CNT_W +: CNT_W] = counts[i];
  end

endmodule

// File: tb/tb_analog_pin_sampler.sv
// Randomised bench for analog_pin_sampler: expected counts are popcounts of a
// per-sample-cycle pin pattern, latency follows the settle + window rule.
module tb_analog_pin_sampler;

  localparam int NUM_PINS = 6;
  localparam int CNT_W    = 16;
  localparam int SETTLE   = 4;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      start;
  logic [CNT_W-1:0]          window;
  logic [NUM_PINS-1:0]       analog_in;
  logic                      busy;
  logic                      result_valid;
  logic                      result_ready;
  logic [NUM_PINS*CNT_W-1:0] result_counts;

  int checks = 0;
  int errors = 0;

  logic [NUM_PINS-1:0] patq[$];
  int                  exp_cnt [NUM_PINS];
  int                  lat;
  bit                  timed_out;

  analog_pin_sampler #(
    .NUM_PINS(NUM_PINS),
    .CNT_W(CNT_W),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .window(window),
    .analog_in(analog_in),
    .busy(busy),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result_counts(result_counts)
  );

  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] cnt_of(input int i);
    return result_counts[i*CNT_W +: CNT_W];
  endfunction

  // Reference: each pin's count is the number of sample cycles in which it is high.
  function automatic void compute_expected();
    for (int i = 0; i < NUM_PINS; i++) exp_cnt[i] = 0;
    foreach (patq[k])
      for (int i = 0; i < NUM_PINS; i++) exp_cnt[i] += int'(patq[k][i]);
  endfunction

  // A pin value driven after edge p is seen by the sample at edge p+3 (two sync
  // stages), so sample k (at edge SETTLE+1+k) is driven after edge SETTLE-2+k.
  task automatic drive_pins(input int p, input int w);
    int k;
    k = p - (SETTLE - 2);
    if (k >= 0 && k < w) analog_in = patq[k];
    else analog_in = NUM_PINS'($urandom);
  endtask

  task automatic run_measure(input int w);
    int p;
    compute_expected();
    @(posedge clk); #1;
    start     = 1'b1;
    window    = CNT_W'(w);
    analog_in = NUM_PINS'($urandom);
    @(posedge clk); #1;
    start     = 1'b0;
    window    = CNT_W'($urandom);
    lat       = 1;
    p         = 0;
    timed_out = 1'b0;
    drive_pins(p, w);
    while (!result_valid) begin
      if (lat > w + SETTLE + 20) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
      p++;
      drive_pins(p, w);
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    start        = 1'b0;
    result_ready = 1'b0;
    window       = '0;
    analog_in    = '0;
    #22;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result_counts !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: busy=%b valid=%b counts=%h expected all 0", busy, result_valid, result_counts);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
  endtask

  task automatic test_basic_pin0();
    patq.delete();
    for (int k = 0; k < 100; k++) patq.push_back(6'b000001);
    result_ready = 1'b1;
    run_measure(100);
    checks++;
    if (timed_out || lat != SETTLE + 100 + 1) begin
      errors++;
      $display("[TB] FAIL basic_latency: got %0d cycles (timeout=%0d) expected %0d", lat, timed_out, SETTLE + 101);
    end
    for (int i = 0; i < NUM_PINS; i++) begin
      checks++;
      if (cnt_of(i) !== CNT_W'(exp_cnt[i])) begin
        errors++;
        $display("[TB] FAIL basic_count%0d: got %0d expected %0d", i, cnt_of(i), exp_cnt[i]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_handshake: busy=%b valid=%b expected 0 0", busy, result_valid);
    end
  endtask

  task automatic test_burst();
    patq.delete();
    for (int k = 0; k < 10; k++) patq.push_back(6'b111111);
    for (int k = 0; k < 10; k++) patq.push_back(6'b000000);
    run_measure(20);
    checks++;
    if (timed_out || lat != SETTLE + 21) begin
      errors++;
      $display("[TB] FAIL burst_latency: got %0d expected %0d", lat, SETTLE + 21);
    end
    for (int i = 0; i < NUM_PINS; i++) begin
      checks++;
      if (cnt_of(i) !== CNT_W'(10)) begin
        errors++;
        $display("[TB] FAIL burst_count%0d: got %0d expected 10", i, cnt_of(i));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_small_windows();
    patq.delete();
    run_measure(0);
    checks++;
    if (timed_out || lat != SETTLE + 1) begin
      errors++;
      $display("[TB] FAIL win0_latency: got %0d expected %0d", lat, SETTLE + 1);
    end
    checks++;
    if (result_counts !== '0) begin
      errors++;
      $display("[TB] FAIL win0_counts: got %h expected 0", result_counts);
    end
    @(posedge clk); #1;
    patq.push_back(6'b001000);
    run_measure(1);
    checks++;
    if (timed_out || lat != SETTLE + 2) begin
      errors++;
      $display("[TB] FAIL win1_latency: got %0d expected %0d", lat, SETTLE + 2);
    end
    for (int i = 0; i < NUM_PINS; i++) begin
      checks++;
      if (cnt_of(i) !== CNT_W'((i == 3) ? 1 : 0)) begin
        errors++;
        $display("[TB] FAIL win1_count%0d: got %0d expected %0d", i, cnt_of(i), (i == 3) ? 1 : 0);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_hold_done();
    logic [NUM_PINS*CNT_W-1:0] held;
    patq.delete();
    for (int k = 0; k < 25; k++) patq.push_back(NUM_PINS'($urandom));
    result_ready = 1'b0;
    run_measure(25);
    for (int i = 0; i < NUM_PINS; i++) begin
      checks++;
      if (timed_out || cnt_of(i) !== CNT_W'(exp_cnt[i])) begin
        errors++;
        $display("[TB] FAIL hold_count%0d: got %0d expected %0d", i, cnt_of(i), exp_cnt[i]);
      end
    end
    held = result_counts;
    for (int c = 0; c < 50; c++) begin
      analog_in = NUM_PINS'($urandom);
      start     = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      checks++;
      if (result_valid !== 1'b1 || result_counts !== held) begin
        errors++;
        $display("[TB] FAIL hold_cycle%0d: valid=%b counts=%h expected 1 %h", c, result_valid, result_counts, held);
      end
    end
    // start together with ready in DONE must be dropped
    start        = 1'b1;
    result_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_release: busy=%b valid=%b expected 0 0", busy, result_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || result_counts !== held) begin
      errors++;
      $display("[TB] FAIL hold_idle: busy=%b counts=%h expected 0 %h", busy, result_counts, held);
    end
  endtask

  task automatic test_reset_mid();
    result_ready = 1'b1;
    analog_in    = 6'b111111;
    @(posedge clk); #1;
    start  = 1'b1;
    window = CNT_W'(30);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (SETTLE + 7) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || cnt_of(0) !== CNT_W'(7)) begin
      errors++;
      $display("[TB] FAIL midrun_partial: busy=%b count0=%0d expected 1 7", busy, cnt_of(0));
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result_counts !== '0) begin
      errors++;
      $display("[TB] FAIL midrun_reset: busy=%b valid=%b counts=%h expected all 0", busy, result_valid, result_counts);
    end
    #3;
    rst_n = 1'b1;
    patq.delete();
    for (int k = 0; k < 30; k++) patq.push_back(6'b100000);
    run_measure(30);
    checks++;
    if (timed_out || lat != SETTLE + 31) begin
      errors++;
      $display("[TB] FAIL after_reset_latency: got %0d expected %0d", lat, SETTLE + 31);
    end
    for (int i = 0; i < NUM_PINS; i++) begin
      checks++;
      if (cnt_of(i) !== CNT_W'((i == 5) ? 30 : 0)) begin
        errors++;
        $display("[TB] FAIL after_reset_count%0d: got %0d expected %0d", i, cnt_of(i), (i == 5) ? 30 : 0);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int w;
    result_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      w = $urandom_range(1, 40);
      patq.delete();
      for (int k = 0; k < w; k++) patq.push_back(NUM_PINS'($urandom));
      run_measure(w);
      checks++;
      if (timed_out || lat != SETTLE + w + 1) begin
        errors++;
        $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", r, lat, SETTLE + w + 1);
      end
      for (int i = 0; i < NUM_PINS; i++) begin
        checks++;
        if (cnt_of(i) !== CNT_W'(exp_cnt[i])) begin
          errors++;
          $display("[TB] FAIL rand%0d_count%0d: got %0d expected %0d", r, i, cnt_of(i), exp_cnt[i]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_max_window();
    patq.delete();
    for (int k = 0; k < 65535; k++) patq.push_back(6'b000100);
    result_ready = 1'b1;
    run_measure(65535);
    checks++;
    if (timed_out || lat != SETTLE + 65536) begin
      errors++;
      $display("[TB] FAIL maxwin_latency: got %0d expected %0d", lat, SETTLE + 65536);
    end
    for (int i = 0; i < NUM_PINS; i++) begin
      checks++;
      if (cnt_of(i) !== CNT_W'(exp_cnt[i])) begin
        errors++;
        $display("[TB] FAIL maxwin_count%0d: got %h expected %h", i, cnt_of(i), exp_cnt[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    $display("[TB] analog_pin_sampler bench start");
    test_reset();
    test_basic_pin0();
    test_burst();
    test_small_windows();
    test_hold_done();
    test_reset_mid();
    test_random();
    test_max_window();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/analog_pin_sampler.md
Name: analog_pin_sampler

Overview:
- Capture stage directly downstream of the FPGA test-analog pin-out block; consumes its six analog output pins.
- Synchronises the pins into the host clock domain, waits a settle interval, then counts the high samples per pin over a programmable window.
- Returns the per-pin counts to the evaluation host through a valid/ready handshake; these counts feed fitness scoring of the configured bitstream.

Parameters:
- NUM_PINS, 6, number of sampled pins (analog0..analog5).
- CNT_W, 16, width of the window register and of each per-pin count.
- SETTLE_CYCLES, 4, cycles waited after start before sampling; legal range 2..255.

Ports:
- clk  input  1  sampling clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a measurement.
- window  input  CNT_W  number of sample cycles; latched when start is accepted.
- analog_in  input  NUM_PINS  raw pins from the pin-out block; bit i = analog_i; asynchronous to clk.
- busy  output  1  high in any state other than IDLE.
- result_valid  output  1  counts available.
- result_ready  input  1  host accepts counts.
- result_counts  output  NUM_PINS*CNT_W  count for pin i in bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset (asynchronous, rst_n low):
  - All outputs and state are 0: busy=0, result_valid=0, result_counts=0.
  - FSM goes to IDLE; synchroniser flops, latched window and all counters are cleared.
  - The same applies when reset is asserted mid-measurement. No partial result is produced.
- Synchroniser:
  - Two flops per pin; the sampled value is the second stage.
  - Synchroniser latency is 2 cycles; SETTLE_CYCLES must be at least 2 to cover it.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 is accepted, and only in IDLE.
  - On acceptance: latch window, clear all counts, clear the settle counter, go to SETTLE.
  - start in any other state is ignored; there is no queueing.
- SETTLE:
  - Lasts exactly SETTLE_CYCLES cycles.
  - Then go to SAMPLE, or go to DONE directly if the latched window is 0.
- SAMPLE:
  - Lasts exactly window cycles.
  - Each cycle, count[i] += sync[i].
  - A count never exceeds window, so there is no overflow and no saturation logic.
  - After the last sample cycle, go to DONE.
- DONE:
  - result_valid=1; result_counts hold stable while valid is high.
  - When result_valid && result_ready is sampled at a clock edge: valid drops on that edge and the FSM returns to IDLE.
  - result_counts keep their values in IDLE until the next accepted start clears them.
- Timing: with start accepted at edge 0, the sample cycles are edges SETTLE_CYCLES+1 .. SETTLE_CYCLES+window. result_valid is high from the cycle after the last sample edge.
  - Latency from start to result_valid = SETTLE_CYCLES + window + 1 cycles; window=0 gives SETTLE_CYCLES + 1.
- Simultaneous events:
  - start together with result_ready in DONE: the handshake completes and start is ignored; the host must reassert start in IDLE.
  - result_ready with result_valid low has no effect.
  - A change on the window input after acceptance has no effect on the running measurement.
- Window boundaries:
  - window=1 gives exactly one sample.
  - window = 2^CNT_W-1 is legal; a constant-high pin yields an all-ones count.

Test Plan:
- Reset, pins constant 6'b000001, start with window=100, result_ready=1 -> result_valid high 105 cycles after start; count0=100, counts1..5=0; busy falls on the handshake.
- Pins 6'b111111 for the first 10 sample cycles then 6'b000000, window=20 -> all six counts=10.
- window=0, start -> result_valid 5 cycles after start with all counts 0; window=1, pin3 high -> count3=1 only.
- Hold result_ready=0 for 50 cycles in DONE while toggling pins and pulsing start -> valid stays high, counts unchanged, second start ignored; ready=1 -> return to IDLE, busy=0.
- Assert rst_n=0 at sample cycle 7 of a window=30 run -> all outputs 0 immediately; after release, a new start with window=30 and pin5 high gives count5=30 (no leftover count).
- window=16'hFFFF, pin2 constant high -> count2=16'hFFFF and other counts 0, no wrap.
